// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: bundles the requester handshake, transmitter drive and status
//   signals of the UART transmit arbiter.
// Latency: none, wiring only.
// Backpressure: req_ready is the only backpressure path toward the byte sources.
// Ports: req_valid/req_data/req_ready (sources), tx_en/tx_data/tx_busy (transmitter),
//   grant_id/done/err_timeout (status), req_lock when UART_ARB_LOCK_EN is defined.
// modport master is the arbiter side; modport slave is the sources + transmitter side.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          tx_en;
  logic [DATA_WIDTH-1:0]         tx_data;
  logic                          tx_busy;
  logic [IW-1:0]                 grant_id;
  logic                          done;
  logic                          err_timeout;
`ifdef UART_ARB_LOCK_EN
  logic [NUM_REQ-1:0]            req_lock;
`endif

  modport master (
    input  req_valid, req_data, tx_busy,
`ifdef UART_ARB_LOCK_EN
    input  req_lock,
`endif
    output req_ready, tx_en, tx_data, grant_id, done, err_timeout
  );

  modport slave (
    output req_valid, req_data, tx_busy,
`ifdef UART_ARB_LOCK_EN
    output req_lock,
`endif
    input  req_ready, tx_en, tx_data, grant_id, done, err_timeout
  );

endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among NUM_REQ byte sources.
// Latency: req_ready in the same cycle a valid is seen in IDLE (tx_busy low), tx_en one cycle later.
// Backpressure: req_ready stays low outside IDLE and while tx_busy is high; sources hold valid/data.
// Ports: clk, rst (synchronous, active-high); bus (uart_tx_arbiter_if.master):
//   req_valid/req_data in, req_ready one-hot out; tx_en pulse, tx_data, tx_busy in;
//   grant_id (last accepted), done (frame finished), err_timeout (busy never rose).
// Optional: define UART_ARB_LOCK_EN to add bus.req_lock, which lets the last granted
//   requester keep the transmitter for consecutive bytes while its lock is held.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_arbiter_if.master bus
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [IW-1:0]         rr_ptr;
  logic [IW-1:0]         grant_q;
  logic [IW-1:0]         win_idx;
  logic [IW-1:0]         sel_idx;
  logic                  win_found;
  logic                  accept;
  logic                  lock_hold;
  logic                  timeout_hit;
  logic                  frame_done;
  logic [NUM_REQ-1:0]    ready_c;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [DATA_WIDTH-1:0] tx_data_q;
  logic                  tx_en_q;
  logic [CW-1:0]         cnt;

  // Slot k positions after base, wrapping at NUM_REQ (NUM_REQ need not be a power of two).
  function automatic logic [IW-1:0] rr_slot(input logic [IW-1:0] base, input int k);
    int s;
    s = (int'(base) + k) % NUM_REQ;
    return IW'(s);
  endfunction

  // Round-robin search: scan from the farthest slot back to rr_ptr+1 so the
  // nearest valid requester after the last winner is the one left standing.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (bus.req_valid[rr_slot(rr_ptr, k)]) begin
        win_found = 1'b1;
        win_idx   = rr_slot(rr_ptr, k);
      end
    end
  end

`ifdef UART_ARB_LOCK_EN
  // lock_active is armed when a frame of a locking requester completes; it
  // holds arbitration on grant_q until that requester drops its lock in IDLE.
  logic lock_active;

  assign lock_hold = lock_active & bus.req_lock[grant_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_active <= 1'b0;
    end else if (frame_done) begin
      lock_active <= bus.req_lock[grant_q];
    end else if (timeout_hit) begin
      lock_active <= 1'b0;
    end else if (state == IDLE && !lock_hold) begin
      lock_active <= 1'b0;
    end
  end
`else
  assign lock_hold = 1'b0;
`endif

  // Next state and combinational outputs. req_ready, done and err_timeout are
  // decoded from the current state so each lasts exactly one cycle.
  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    sel_idx     = win_idx;
    ready_c     = '0;
    timeout_hit = 1'b0;
    frame_done  = 1'b0;
    case (state)
      IDLE: begin
        if (!bus.tx_busy) begin
          if (lock_hold) begin
            sel_idx = grant_q;
            accept  = bus.req_valid[grant_q];
          end else begin
            accept  = win_found;
          end
          if (accept) begin
            ready_c[sel_idx] = 1'b1;
            state_nxt        = ISSUE;
          end
        end
      end
      ISSUE: begin
        state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (bus.tx_busy) begin
          state_nxt = WAIT_DONE;
        end else if (cnt == CNT_LAST) begin
          // Byte is dropped; the transmitter never acknowledged it.
          timeout_hit = 1'b1;
          state_nxt   = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) begin
          frame_done = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Payload mux for the selected requester.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel_idx == IW'(i)) begin
        sel_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // tx_data/grant_id/rr_ptr move only on accept, so tx_data is stable for the
  // whole frame. tx_en is registered and high only in the ISSUE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_en_q   <= 1'b0;
      tx_data_q <= '0;
      grant_q   <= '0;
      rr_ptr    <= IW'(NUM_REQ - 1);
      cnt       <= '0;
    end else begin
      tx_en_q <= (state_nxt == ISSUE);
      if (accept) begin
        tx_data_q <= sel_data;
        grant_q   <= sel_idx;
        rr_ptr    <= sel_idx;
      end
      if (state == ISSUE) begin
        cnt <= '0;
      end else if (state == WAIT_BUSY && !bus.tx_busy) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign bus.req_ready   = ready_c;
  assign bus.tx_en       = tx_en_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.grant_id    = grant_q;
  assign bus.done        = frame_done;
  assign bus.err_timeout = timeout_hit;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and randomized frames against a transaction-level
//   model of the round-robin arbiter and a simple transmitter busy model.
// Latency/backpressure expectations are derived per frame from the arbitration rules.
module tb_uart_tx_arbiter;

  localparam int NR  = 4;
  localparam int DW  = 8;
  localparam int ACK = 16;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .ACK_TIMEOUT(ACK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  // Requester-side stimulus state and model state.
  logic          val [NR];
  logic [DW-1:0] dat [NR];
  logic          lk  [NR];
  int            model_last;
  bit            model_locked;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_reqs();
    logic [NR-1:0]    v;
    logic [NR*DW-1:0] d;
`ifdef UART_ARB_LOCK_EN
    logic [NR-1:0]    l;
`endif
    for (int i = 0; i < NR; i++) begin
      v[i]          = val[i];
      d[i*DW +: DW] = dat[i];
`ifdef UART_ARB_LOCK_EN
      l[i]          = lk[i];
`endif
    end
    bus.req_valid = v;
    bus.req_data  = d;
`ifdef UART_ARB_LOCK_EN
    bus.req_lock  = l;
`endif
  endtask

  // Holds rst for n cycles, then checks every output in the first cycle after.
  task automatic do_reset(input int n);
    rst         = 1'b1;
    bus.tx_busy = 1'b0;
    for (int i = 0; i < NR; i++) begin
      val[i] = 1'b0;
      lk[i]  = 1'b0;
    end
    drive_reqs();
    repeat (n) next_cycle();
    rst          = 1'b0;
    model_last   = NR - 1;
    model_locked = 1'b0;
    @(negedge clk);
    check("rst_ready",   32'(bus.req_ready),   32'd0);
    check("rst_txen",    32'(bus.tx_en),       32'd0);
    check("rst_txdata",  32'(bus.tx_data),     32'd0);
    check("rst_gid",     32'(bus.grant_id),    32'd0);
    check("rst_done",    32'(bus.done),        32'd0);
    check("rst_timeout", 32'(bus.err_timeout), 32'd0);
    next_cycle();
  endtask

  // IDLE with transmitter busy: nothing may be granted or issued.
  task automatic busy_blocked(input int n);
    bus.tx_busy = 1'b1;
    drive_reqs();
    repeat (n) begin
      @(negedge clk);
      check("blk_ready", 32'(bus.req_ready), 32'd0);
      check("blk_txen",  32'(bus.tx_en),     32'd0);
      next_cycle();
    end
    bus.tx_busy = 1'b0;
  endtask

  // One arbitration attempt starting in IDLE.
  //   d: cycle after ISSUE at which busy rises (0 = never, expect timeout)
  //   len: number of cycles busy stays high
  //   mode: what the accepted requester does next (0 keep, 1 random, 2 drop, 3 drop + unlock)
  //   hold_busy: return mid-frame with busy still high
  //   obs_gid/obs_dat: grant_id/tx_data seen on the DUT in the ISSUE cycle (-1 if no grant)
  task automatic frame(input int d, input int len, input int mode, input bit hold_busy,
                       output int obs_gid, output logic [DW-1:0] obs_dat);
    int            exp;
    logic [DW-1:0] exp_dat;
    obs_gid = -1;
    obs_dat = '0;
    drive_reqs();
    if (model_locked && !lk[model_last]) model_locked = 1'b0;
    exp = -1;
    if (model_locked) begin
      if (val[model_last]) exp = model_last;
    end else begin
      for (int k = 1; k <= NR; k++) begin
        if (exp < 0 && val[(model_last + k) % NR]) exp = (model_last + k) % NR;
      end
    end
    @(negedge clk);
    check("accept_ready", 32'(bus.req_ready), (exp < 0) ? 32'd0 : (32'd1 << exp));
    check("accept_txen",  32'(bus.tx_en), 32'd0);
    next_cycle();
    if (exp < 0) return;
    exp_dat    = dat[exp];
    model_last = exp;
    case (mode)
      1: begin
        val[exp] = 1'($urandom_range(0, 1));
        dat[exp] = DW'($urandom);
      end
      2: val[exp] = 1'b0;
      3: begin
        val[exp] = 1'b0;
        lk[exp]  = 1'b0;
      end
      default: ;
    endcase
    drive_reqs();
    @(negedge clk);
    obs_gid = int'(bus.grant_id);
    obs_dat = bus.tx_data;
    check("issue_txen",    32'(bus.tx_en),       32'd1);
    check("issue_data",    32'(bus.tx_data),     32'(exp_dat));
    check("issue_gid",     32'(bus.grant_id),    32'(exp));
    check("issue_ready",   32'(bus.req_ready),   32'd0);
    check("issue_done",    32'(bus.done),        32'd0);
    check("issue_timeout", 32'(bus.err_timeout), 32'd0);
    next_cycle();
    for (int t = 1; t <= ACK; t++) begin
      if (t == d) bus.tx_busy = 1'b1;
      @(negedge clk);
      check("wb_txen",    32'(bus.tx_en),       32'd0);
      check("wb_ready",   32'(bus.req_ready),   32'd0);
      check("wb_done",    32'(bus.done),        32'd0);
      check("wb_timeout", 32'(bus.err_timeout), 32'(d == 0 && t == ACK));
      check("wb_data",    32'(bus.tx_data),     32'(exp_dat));
      next_cycle();
      if (t == d) break;
    end
    if (d == 0) begin
      model_locked = 1'b0;
      return;
    end
    for (int b = 1; b < len; b++) begin
      @(negedge clk);
      check("busy_done",    32'(bus.done),        32'd0);
      check("busy_ready",   32'(bus.req_ready),   32'd0);
      check("busy_timeout", 32'(bus.err_timeout), 32'd0);
      check("busy_data",    32'(bus.tx_data),     32'(exp_dat));
      next_cycle();
    end
    if (hold_busy) return;
    bus.tx_busy = 1'b0;
    @(negedge clk);
    check("frame_done",    32'(bus.done),        32'd1);
    check("frame_ready",   32'(bus.req_ready),   32'd0);
    check("frame_timeout", 32'(bus.err_timeout), 32'd0);
    model_locked = lk[model_last];
    next_cycle();
  endtask

  initial begin
    int            g;
    logic [DW-1:0] gd;
    int            d;
    int            exp_order [5] = '{0, 1, 2, 3, 0};

    rst         = 1'b1;
    bus.tx_busy = 1'b0;
    for (int i = 0; i < NR; i++) begin
      val[i] = 1'b0;
      dat[i] = '0;
      lk[i]  = 1'b0;
    end
    drive_reqs();

    // Reset, then a single byte from requester 2 with a long busy period.
    do_reset(2);
    val[2] = 1'b1;
    dat[2] = 8'hA5;
    frame(2, 100, 2, 1'b0, g, gd);
    check("single_gid",  32'(g),  32'd2);
    check("single_data", 32'(gd), 32'hA5);
    check("single_gid_held", 32'(bus.grant_id), 32'd2);

    // All four continuously valid: strict rotation from requester 0.
    do_reset(1);
    for (int i = 0; i < NR; i++) begin
      val[i] = 1'b1;
      dat[i] = 8'h10 + 8'(i);
    end
    for (int n = 0; n < 5; n++) begin
      frame(1, 2, 0, 1'b0, g, gd);
      check("rr_order", 32'(g),  32'(exp_order[n]));
      check("rr_data",  32'(gd), 32'(8'h10 + 8'(exp_order[n])));
    end
    for (int i = 0; i < NR; i++) val[i] = 1'b0;

    // Transmitter busy in IDLE blocks the grant; accept follows once it drops.
    val[0] = 1'b1;
    dat[0] = 8'h3C;
    busy_blocked(6);
    frame(3, 4, 2, 1'b0, g, gd);
    check("blk_gid", 32'(g), 32'd0);

    // Busy never rises: timeout, byte dropped, next requester still served.
    val[1] = 1'b1;
    dat[1] = 8'h5A;
    frame(0, 1, 2, 1'b0, g, gd);
    check("to_gid", 32'(g), 32'd1);
    val[2] = 1'b1;
    dat[2] = 8'h77;
    frame(1, 3, 2, 1'b0, g, gd);
    check("after_to_gid",  32'(g),  32'd2);
    check("after_to_data", 32'(gd), 32'h77);

    // Reset in WAIT_DONE, then contention between 0 and 3 goes to 0 first.
    val[1] = 1'b1;
    dat[1] = 8'hC3;
    frame(1, 3, 2, 1'b1, g, gd);
    do_reset(1);
    val[0] = 1'b1;
    dat[0] = 8'h40;
    val[3] = 1'b1;
    dat[3] = 8'h43;
    frame(2, 2, 2, 1'b0, g, gd);
    check("post_rst_gid", 32'(g), 32'd0);
    frame(2, 2, 2, 1'b0, g, gd);
    check("post_rst_gid2", 32'(g), 32'd3);

`ifdef UART_ARB_LOCK_EN
    // Requester 1 keeps the transmitter for three bytes while 0 and 3 wait.
    do_reset(1);
    val[0] = 1'b1;
    dat[0] = 8'h01;
    frame(1, 1, 2, 1'b0, g, gd);
    check("lock_pre_gid", 32'(g), 32'd0);
    val[0] = 1'b1;
    val[1] = 1'b1;
    val[3] = 1'b1;
    dat[1] = 8'hB1;
    lk[1]  = 1'b1;
    frame(1, 1, 0, 1'b0, g, gd);
    check("lock_gid_a", 32'(g), 32'd1);
    frame(1, 1, 0, 1'b0, g, gd);
    check("lock_gid_b", 32'(g), 32'd1);
    frame(1, 1, 3, 1'b0, g, gd);
    check("lock_gid_c", 32'(g), 32'd1);
    frame(1, 1, 2, 1'b0, g, gd);
    check("lock_rel_gid_a", 32'(g), 32'd3);
    frame(1, 1, 2, 1'b0, g, gd);
    check("lock_rel_gid_b", 32'(g), 32'd0);
`endif

    // Randomized traffic: new requests arrive, random busy timing, some timeouts.
    do_reset(1);
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < NR; i++) begin
        if (!val[i] && $urandom_range(0, 2) == 0) begin
          val[i] = 1'b1;
          dat[i] = DW'($urandom);
        end
      end
      if ($urandom_range(0, 4) == 0) busy_blocked(int'($urandom_range(1, 5)));
      d = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, ACK));
      frame(d, int'($urandom_range(1, 8)), 1, 1'b0, g, gd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter among NUM_REQ byte sources with valid/ready handshakes.
- Round-robin selection of the next requester; the chosen byte is latched and issued to the transmitter as a one-cycle tx_en pulse.
- Tracks transmitter busy through the whole frame, then re-arbitrates.
- Sits between the producer blocks (command/status/debug sources) and the UART transmitter.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 8, frame payload width; must match the transmitter's data width.
- ACK_TIMEOUT, 16, cycles to wait for tx_busy to rise after tx_en before aborting (>=2).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester byte valid.
- req_data  input  NUM_REQ*DATA_WIDTH  flattened payloads; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  output  NUM_REQ  one-hot accept; a transfer occurs when valid&ready.
- tx_en  output  1  one-cycle start pulse to the transmitter.
- tx_data  output  DATA_WIDTH  latched payload to the transmitter's data_in.
- tx_busy  input  1  transmitter busy.
- grant_id  output  clog2(NUM_REQ) (min 1)  index of the last accepted requester.
- done  output  1  one-cycle pulse when a frame completes (busy falls).
- err_timeout  output  1  one-cycle pulse when tx_busy never rose.

Behaviour:
- Interface (already decided): one clock, clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE, req_ready=0, tx_en=0, tx_data=0, grant_id=0, done=0, err_timeout=0, rr pointer=NUM_REQ-1, so requester 0 has first priority.
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - If tx_busy==0 and any req_valid: winner = first valid index searching from rr_ptr+1 upward, with modulo wrap.
  - req_ready[winner]=1 combinationally in this cycle.
  - Register tx_data=req_data[winner], grant_id=winner, rr_ptr=winner; go to ISSUE.
  - If tx_busy==1 in IDLE: no grant and req_ready=0, whatever the valids.
- ISSUE: tx_en=1 for exactly this cycle (registered, asserted on state entry); tx_data held stable; go to WAIT_BUSY; clear the timeout counter.
- WAIT_BUSY:
  - If tx_busy==1, go to WAIT_DONE.
  - Else if counter==ACK_TIMEOUT-1: pulse err_timeout for one cycle, go to IDLE, drop the byte (no retry).
  - Otherwise increment the counter.
- WAIT_DONE: when tx_busy==0, pulse done for one cycle and go to IDLE.
- req_ready is only ever asserted in IDLE and is at most one-hot.
- Requesters hold req_valid and req_data stable until accepted, and may drop req_valid only after acceptance.
- Latency: valid seen at cycle N (IDLE, not busy) gives ready at N and tx_en at N+1. Next accept is possible in the cycle after done.
- tx_data changes only on accept, so it stays stable for the whole frame.
- Fairness: with all requesters valid continuously, grants rotate 0,1,2,3,0… with no requester granted twice before the others.
- Simultaneous events:
  - A valid arriving during ISSUE/WAIT_* waits for IDLE.
  - If tx_busy falls and a valid is present in the same cycle, done pulses in WAIT_DONE; the grant occurs the following IDLE cycle.
- Reset mid-frame: all state returns to reset values immediately. tx_en is never left high; the transmitter's own reset governs the line.

Optional Feature:
- Macro UART_ARB_LOCK_EN.
- With it defined:
  - Extra input req_lock [NUM_REQ].
  - If req_lock[grant_id] is high when done pulses, the next IDLE only considers requester grant_id (it waits while that requester's valid is low and its lock remains high). Other requesters are not granted.
  - Lock release = req_lock[grant_id] low in IDLE, after which normal round-robin resumes from grant_id+1.
  - A timeout also releases the lock.
- Without it: no req_lock port; pure round-robin per byte.

Test Plan:
- Reset then a single byte: rst high 2 cycles; req_valid=4'b0100, data 8'hA5.
  - Expect req_ready=4'b0100 the same cycle, tx_en 1 cycle later, tx_data=8'hA5, grant_id=2.
  - Model busy high 2 cycles later for 100 cycles; expect done one cycle after busy falls.
- Round-robin: all four valid continuously with data 8'h10,8'h11,8'h12,8'h13.
  - Expect grant order 0,1,2,3,0 and tx_data order 10,11,12,13,10; no double grant.
- Busy-blocked IDLE: tx_busy held high externally, req_valid=4'b0001.
  - No req_ready and no tx_en until busy drops; then accept within 1 cycle.
- Timeout: transmitter model never raises busy, ACK_TIMEOUT=16.
  - err_timeout pulses exactly 16 cycles after the ISSUE cycle; FSM returns to IDLE; no done pulse; the next requester is accepted.
- Reset mid-frame: assert rst during WAIT_DONE.
  - All outputs zero the next cycle; rr restarts so requester 0 wins the next contention among {0,3}.
- (UART_ARB_LOCK_EN) Requester 1 holds lock for 3 bytes while 0 and 3 are valid.
  - Grants 1,1,1, then 3,0 after the lock drops.
